// File: rtl/dma_peripheral_requester_if.sv
// Bundle of the local stream, DMA handshake and data-bus signals of the peripheral requester.
// slave: the requester itself; master: the DMA controller plus local source/sink around it.
interface dma_peripheral_requester_if #(
    parameter int LEN_W = 16
);
    logic             enable;
    logic             dir;
    logic [LEN_W-1:0] block_len;
    logic             src_valid;
    logic [7:0]       src_data;
    logic             src_ready;
    logic             snk_valid;
    logic [7:0]       snk_data;
    logic             snk_ready;
    logic             dreq;
    logic             dack;
    logic             ior_n;
    logic             iow_n;
    logic [7:0]       db_in;
    logic [7:0]       db_out;
    logic             db_oe;
    logic             eop_n_in;
    logic             eop_oe;
    logic             done;
    logic             err;

    modport slave (
        input  enable, dir, block_len, src_valid, src_data, snk_ready,
               dack, ior_n, iow_n, db_in, eop_n_in,
        output src_ready, snk_valid, snk_data, dreq, db_out, db_oe, eop_oe, done, err
    );

    modport master (
        output enable, dir, block_len, src_valid, src_data, snk_ready,
               dack, ior_n, iow_n, db_in, eop_n_in,
        input  src_ready, snk_valid, snk_data, dreq, db_out, db_oe, eop_oe, done, err
    );
endinterface

// File: rtl/dma_peripheral_requester.sv
// Device-side 8237-style DMA requester: byte FIFO, block counter, DREQ/DACK strobe handling, EOP.
// Optional DMA_PERIPH_WATERMARK_EN: DREQ waits for min(WATERMARK, remaining) bytes or free slots.
module dma_peripheral_requester #(
    parameter int FIFO_DEPTH = 8,
    parameter int WATERMARK  = 4,
    parameter int LEN_W      = 16
) (
    input logic                       clk,
    input logic                       rst,
    dma_peripheral_requester_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        WATERMARK < 1 || WATERMARK > FIFO_DEPTH) begin : g_param_check
        $error("dma_peripheral_requester: illegal FIFO_DEPTH or WATERMARK");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t           state, state_nx;
    logic             dir_q, dir_nx;
    logic [LEN_W-1:0] remaining, remaining_nx;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_nx;
    logic [CW-1:0]    count, count_nx, level;
    logic             cyc_open, cyc_open_nx;
    logic             eop_seen, eop_seen_nx;
    logic [7:0]       cap;
    logic             dreq_q, dreq_nx;
    logic [7:0]       db_out_q, db_out_nx;
    logic             err_q;

    logic       active, dir_mode, full, empty, strobe_n, strobe_low;
    logic       bad_now, opening, commit, capture, eop_hit, last_byte;
    logic       src_ready_w, snk_valid_w, push, pop;
    logic [7:0] push_data;

    function automatic logic level_ok(input logic [CW-1:0] lvl, input logic [LEN_W-1:0] rem);
`ifdef DMA_PERIPH_WATERMARK_EN
        int unsigned thr;
        thr = (32'(rem) < 32'(WATERMARK)) ? 32'(rem) : 32'(WATERMARK);
        return (rem != '0) && (32'(lvl) >= thr);
`else
        return (rem != '0) && (lvl != '0);
`endif
    endfunction

    assign active     = (state == S_ACTIVE);
    // Outside a block the local side follows the live DIR so the FIFO can be pre-filled.
    assign dir_mode   = (state == S_IDLE) ? bus.dir : dir_q;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign strobe_n   = dir_q ? bus.ior_n : bus.iow_n;
    assign strobe_low = active && bus.dack && !strobe_n;
    assign bad_now    = strobe_low && (dir_q ? empty : full);
    assign opening    = strobe_low && !bad_now && !cyc_open;
    assign commit     = cyc_open && active && bus.enable && strobe_n;
    assign capture    = opening || (cyc_open && !strobe_n);
    assign eop_hit    = eop_seen || !bus.eop_n_in;
    assign last_byte  = (remaining == LEN_W'(1));

    assign src_ready_w = !rst && !full && dir_mode;
    assign snk_valid_w = !empty && !dir_mode;

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        push_data = bus.src_data;
        if (dir_mode) begin
            push = bus.src_valid && src_ready_w;
            pop  = commit;
        end else begin
            push      = commit;
            push_data = cap;
            pop       = snk_valid_w && bus.snk_ready;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bus.enable) state_nx = (bus.block_len == '0) ? S_DONE : S_ACTIVE;
            S_ACTIVE: begin
                if (!bus.enable)
                    state_nx = S_IDLE;
                else if (commit && (last_byte || eop_hit))
                    state_nx = S_DONE;
            end
            S_DONE:   if (!bus.enable) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        remaining_nx = remaining;
        if (state == S_IDLE && bus.enable)
            remaining_nx = bus.block_len;
        else if (commit && remaining != '0)
            remaining_nx = remaining - LEN_W'(1);

        count_nx = count + CW'(push) - CW'(pop);
        rd_nx    = rd_ptr + AW'(pop);

        cyc_open_nx = (state_nx == S_ACTIVE) && (opening || (cyc_open && !commit));
        eop_seen_nx = cyc_open_nx && eop_hit;

        // A byte that lands in an empty FIFO is bypassed straight to the bus register.
        if (bad_now)
            db_out_nx = 8'hFF;
        else if (count_nx == '0)
            db_out_nx = 8'h00;
        else if (push && (count == CW'(pop)))
            db_out_nx = push_data;
        else
            db_out_nx = mem[rd_nx];

        dir_nx = (state == S_IDLE) ? bus.dir : dir_q;
        level  = dir_nx ? count_nx : CW'(FIFO_DEPTH) - count_nx;
        if (state_nx != S_ACTIVE)
            dreq_nx = 1'b0;
        else if (commit || !dreq_q)
            dreq_nx = level_ok(level, remaining_nx);
        else
            dreq_nx = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dir_q     <= 1'b0;
            remaining <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cyc_open  <= 1'b0;
            eop_seen  <= 1'b0;
            cap       <= '0;
            dreq_q    <= 1'b0;
            db_out_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            if (state == S_IDLE && bus.enable)
                dir_q <= bus.dir;
            remaining <= remaining_nx;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_nx;
            count     <= count_nx;
            cyc_open  <= cyc_open_nx;
            eop_seen  <= eop_seen_nx;
            if (capture)
                cap <= bus.db_in;
            dreq_q    <= dreq_nx;
            db_out_q  <= db_out_nx;
            if (bad_now || (bus.dack && !active))
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign bus.src_ready = src_ready_w;
    assign bus.snk_valid = snk_valid_w;
    assign bus.snk_data  = mem[rd_ptr];
    assign bus.dreq      = dreq_q;
    assign bus.db_out    = db_out_q;
    assign bus.db_oe     = bus.dack && !bus.ior_n && active && dir_q;
    assign bus.eop_oe    = bus.dack && last_byte && !strobe_n && active;
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dma_peripheral_requester.sv
// Randomised self-checking bench for dma_peripheral_requester against a queue-based block model.
module tb_dma_peripheral_requester;
    localparam int LEN_W = 16;
    localparam int DEPTH = 8;
    localparam int WM    = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] fq[$];
    int         rem_m;

    always #5 clk = ~clk;

    dma_peripheral_requester_if #(.LEN_W(LEN_W)) bus ();

    dma_peripheral_requester #(.FIFO_DEPTH(DEPTH), .WATERMARK(WM), .LEN_W(LEN_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic exp_dreq(input int lvl, input int rem);
`ifdef DMA_PERIPH_WATERMARK_EN
        int thr = (rem < WM) ? rem : WM;
`else
        int thr = 1;
`endif
        return (rem > 0) && (lvl >= thr);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enable = 1'b0; bus.dir = 1'b1; bus.block_len = '0;
        bus.src_valid = 1'b0; bus.src_data = '0; bus.snk_ready = 1'b0;
        bus.dack = 1'b0; bus.ior_n = 1'b1; bus.iow_n = 1'b1;
        bus.db_in = '0; bus.eop_n_in = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        fq.delete();
        rem_m = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.src_valid = 1'b1;
        bus.src_data  = b;
        tick();
        bus.src_valid = 1'b0;
        fq.push_back(b);
    endtask

    task automatic arm(input logic d, input int len);
        bus.dir       = d;
        bus.block_len = LEN_W'(len);
        bus.enable    = 1'b1;
        tick();
        rem_m = len;
    endtask

    task automatic read_pulse(input logic eop, output logic [7:0] seen,
                              output logic oe_low, output logic oe_high, output logic eop_low);
        bus.dack = 1'b1; bus.ior_n = 1'b0; bus.eop_n_in = !eop;
        #1;
        oe_low  = bus.db_oe;
        eop_low = bus.eop_oe;
        tick();
        tick();
        seen    = bus.db_out;
        oe_low  = oe_low & bus.db_oe;
        eop_low = eop_low | bus.eop_oe;
        bus.ior_n = 1'b1; bus.dack = 1'b0; bus.eop_n_in = 1'b1;
        #1;
        oe_high = bus.db_oe;
        tick();
    endtask

    task automatic write_pulse(input logic [7:0] b);
        bus.dack = 1'b1; bus.iow_n = 1'b0; bus.db_in = ~b;
        tick();
        bus.db_in = b;
        tick();
        bus.iow_n = 1'b1; bus.dack = 1'b0; bus.db_in = 8'($urandom);
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        tests++; if ({bus.dreq, bus.db_oe, bus.eop_oe, bus.done, bus.err, bus.src_ready, bus.snk_valid} !== 7'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 0000000",
                {bus.dreq, bus.db_oe, bus.eop_oe, bus.done, bus.err, bus.src_ready, bus.snk_valid}); end
        tests++; if (bus.db_out !== 8'h00) begin fails++; $display("FAIL reset_db_out: got %h want 00", bus.db_out); end
        tick();
        rst = 1'b0;
        tick();
        fq.delete();
        tests++; if (bus.src_ready !== 1'b1) begin fails++; $display("FAIL reset_src_ready: got %b want 1", bus.src_ready); end
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        arm(1'b1, 2);
        tests++; if (bus.dreq !== exp_dreq(fq.size(), rem_m)) begin
            fails++; $display("FAIL reset_pre_dreq: got %b want %b", bus.dreq, exp_dreq(fq.size(), rem_m)); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({bus.dreq, bus.done, bus.src_ready} !== 3'b000 || dut.count !== '0) begin
            fails++; $display("FAIL reset_async: got dreq/done/ready %b count %0d want 000 count 0",
                {bus.dreq, bus.done, bus.src_ready}, dut.count); end
        idle_inputs();
        #1;
        rst = 1'b0;
        tick();
        fq.delete();
    endtask

    task automatic test_read_block();
        logic [7:0] seen; logic oe_l, oe_h, eop_l;
        do_reset();
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
        arm(1'b1, 3);
        tests++; if (bus.dreq !== 1'b1) begin fails++; $display("FAIL rd_dreq_arm: got %b want 1", bus.dreq); end
        for (int k = 0; k < 3; k++) begin
            read_pulse(1'b0, seen, oe_l, oe_h, eop_l);
            tests++; if (seen !== fq[0]) begin fails++; $display("FAIL rd_db_out[%0d]: got %h want %h", k, seen, fq[0]); end
            tests++; if ({oe_l, oe_h} !== 2'b10) begin fails++; $display("FAIL rd_db_oe[%0d]: got low/high %b want 10", k, {oe_l, oe_h}); end
            tests++; if (eop_l !== (k == 2)) begin fails++; $display("FAIL rd_eop_oe[%0d]: got %b want %b", k, eop_l, (k == 2)); end
            void'(fq.pop_front());
            rem_m--;
        end
        tests++; if ({bus.done, bus.dreq, bus.err} !== 3'b100) begin
            fails++; $display("FAIL rd_end: got done/dreq/err %b want 100", {bus.done, bus.dreq, bus.err}); end
        bus.enable = 1'b0;
        tick();
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rd_done_clear: got %b want 0", bus.done); end
    endtask

    task automatic test_random_read();
        logic [7:0] seen; logic oe_l, oe_h, eop_l;
        int len, pre, pushed;
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            len = int'($urandom_range(1, 14));
            pre = int'($urandom_range(1, DEPTH));
            if (pre > len) pre = len;
            for (int i = 0; i < pre; i++) push_byte(8'($urandom));
            pushed = pre;
            arm(1'b1, len);
            tests++; if (bus.dreq !== exp_dreq(fq.size(), rem_m)) begin
                fails++; $display("FAIL rr_dreq_arm[%0d]: got %b want %b", blk, bus.dreq, exp_dreq(fq.size(), rem_m)); end
            while (rem_m > 0) begin
                read_pulse(1'b0, seen, oe_l, oe_h, eop_l);
                tests++; if (seen !== fq[0]) begin fails++; $display("FAIL rr_byte[%0d]: got %h want %h", blk, seen, fq[0]); end
                void'(fq.pop_front());
                rem_m--;
                if (pushed < len && (fq.size() == 0 || $urandom_range(0, 1) == 1)) begin
                    push_byte(8'($urandom));
                    pushed++;
                end
                if (rem_m > 0) begin
                    tests++; if (bus.dreq !== exp_dreq(fq.size(), rem_m)) begin
                        fails++; $display("FAIL rr_dreq[%0d]: got %b want %b", blk, bus.dreq, exp_dreq(fq.size(), rem_m)); end
                end
            end
            tests++; if ({bus.done, bus.dreq, bus.err} !== 3'b100) begin
                fails++; $display("FAIL rr_end[%0d]: got done/dreq/err %b want 100", blk, {bus.done, bus.dreq, bus.err}); end
            bus.enable = 1'b0;
            tick();
        end
    endtask

    task automatic test_write_block();
        logic [7:0] vals[$];
        int len;
        do_reset();
        bus.snk_ready = 1'b1;
        for (int blk = 0; blk < 3; blk++) begin
            vals.delete();
            if (blk == 0) begin
                vals.push_back(8'h5C); vals.push_back(8'h3D);
            end else begin
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) vals.push_back(8'($urandom));
            end
            arm(1'b0, vals.size());
            tests++; if (bus.dreq !== exp_dreq(DEPTH, rem_m)) begin
                fails++; $display("FAIL wr_dreq_arm[%0d]: got %b want %b", blk, bus.dreq, exp_dreq(DEPTH, rem_m)); end
            foreach (vals[i]) begin
                write_pulse(vals[i]);
                fq.push_back(vals[i]);
                rem_m--;
                tests++; if (bus.snk_valid !== 1'b1 || bus.snk_data !== fq[0]) begin
                    fails++; $display("FAIL wr_snk[%0d.%0d]: got v=%b %h want v=1 %h", blk, i, bus.snk_valid, bus.snk_data, fq[0]); end
                if (rem_m > 0) begin
                    tests++; if (bus.dreq !== exp_dreq(DEPTH - fq.size(), rem_m)) begin
                        fails++; $display("FAIL wr_dreq[%0d.%0d]: got %b want %b", blk, i, bus.dreq, exp_dreq(DEPTH - fq.size(), rem_m)); end
                end
                void'(fq.pop_front());
            end
            tests++; if ({bus.done, bus.dreq, bus.err, bus.db_oe} !== 4'b1000) begin
                fails++; $display("FAIL wr_end[%0d]: got done/dreq/err/oe %b want 1000", blk, {bus.done, bus.dreq, bus.err, bus.db_oe}); end
            tick();
            tests++; if (bus.snk_valid !== 1'b0) begin fails++; $display("FAIL wr_empty[%0d]: got %b want 0", blk, bus.snk_valid); end
            bus.enable = 1'b0;
            tick();
        end
        bus.snk_ready = 1'b0;
    endtask

    task automatic test_eop();
        logic [7:0] seen; logic oe_l, oe_h, eop_l, eop_any;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
        arm(1'b1, 10);
        eop_any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL eop_early_done[%0d]: got %b want 0", k, bus.done); end
            read_pulse(k == 3, seen, oe_l, oe_h, eop_l);
            eop_any = eop_any | eop_l;
            tests++; if (seen !== fq[0]) begin fails++; $display("FAIL eop_byte[%0d]: got %h want %h", k, seen, fq[0]); end
            void'(fq.pop_front());
            rem_m--;
        end
        tests++; if ({bus.done, bus.dreq, eop_any} !== 3'b100) begin
            fails++; $display("FAIL eop_end: got done/dreq/eop_oe %b want 100", {bus.done, bus.dreq, eop_any}); end
        tests++; if (int'(dut.remaining) !== rem_m) begin fails++; $display("FAIL eop_remaining: got %0d want %0d", dut.remaining, rem_m); end
        bus.enable = 1'b0;
        tick();
    endtask

    task automatic test_err();
        do_reset();
        arm(1'b1, 3);
        tests++; if (bus.dreq !== 1'b0) begin fails++; $display("FAIL err_dreq_empty: got %b want 0", bus.dreq); end
        bus.dack = 1'b1; bus.ior_n = 1'b0;
        tick();
        tests++; if (bus.err !== 1'b1 || bus.db_out !== 8'hFF) begin
            fails++; $display("FAIL err_set: got err=%b db_out=%h want err=1 db_out=ff", bus.err, bus.db_out); end
        bus.ior_n = 1'b1; bus.dack = 1'b0;
        tick();
        tests++; if (int'(dut.remaining) !== 3 || dut.count !== '0) begin
            fails++; $display("FAIL err_no_move: got rem=%0d count=%0d want rem=3 count=0", dut.remaining, dut.count); end
        bus.enable = 1'b0;
        tick(); tick();
        tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", bus.err); end
        do_reset();
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", bus.err); end
        bus.dack = 1'b1;
        tick();
        bus.dack = 1'b0;
        tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL err_dack_idle: got %b want 1", bus.err); end
        do_reset();
    endtask

    task automatic test_wrap();
        logic [7:0] seen; logic oe_l, oe_h, eop_l;
        logic [7:0] b;
        int pushed;
        do_reset();
        arm(1'b1, 12);
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
        tests++; if (bus.src_ready !== 1'b0 || int'(dut.count) !== DEPTH) begin
            fails++; $display("FAIL wrap_full: got ready=%b count=%0d want ready=0 count=%0d", bus.src_ready, dut.count, DEPTH); end
        read_pulse(1'b0, seen, oe_l, oe_h, eop_l);
        tests++; if (seen !== fq[0]) begin fails++; $display("FAIL wrap_first: got %h want %h", seen, fq[0]); end
        void'(fq.pop_front());
        rem_m--;
        b = 8'($urandom);
        bus.dack = 1'b1; bus.ior_n = 1'b0;
        tick(); tick();
        tests++; if (bus.db_out !== fq[0]) begin fails++; $display("FAIL wrap_simul_byte: got %h want %h", bus.db_out, fq[0]); end
        bus.ior_n = 1'b1; bus.dack = 1'b0;
        bus.src_valid = 1'b1; bus.src_data = b;
        tick();
        bus.src_valid = 1'b0;
        void'(fq.pop_front());
        fq.push_back(b);
        rem_m--;
        pushed = DEPTH + 1;
        tests++; if (int'(dut.count) !== fq.size()) begin
            fails++; $display("FAIL wrap_simul_count: got %0d want %0d", dut.count, fq.size()); end
        while (rem_m > 0) begin
            read_pulse(1'b0, seen, oe_l, oe_h, eop_l);
            tests++; if (seen !== fq[0]) begin fails++; $display("FAIL wrap_order[%0d]: got %h want %h", rem_m, seen, fq[0]); end
            void'(fq.pop_front());
            rem_m--;
            if (pushed < 12) begin
                push_byte(8'($urandom));
                pushed++;
            end
        end
        tests++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            fails++; $display("FAIL wrap_end: got done=%b err=%b want done=1 err=0", bus.done, bus.err); end
        bus.enable = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] seen; logic oe_l, oe_h, eop_l;
        do_reset();
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        arm(1'b1, 5);
        bus.dack = 1'b1; bus.ior_n = 1'b0;
        tick(); tick();
        bus.enable = 1'b0;
        tick();
        tests++; if ({bus.dreq, bus.db_oe, bus.done} !== 3'b000) begin
            fails++; $display("FAIL abort_idle: got dreq/oe/done %b want 000", {bus.dreq, bus.db_oe, bus.done}); end
        bus.dack = 1'b0; bus.ior_n = 1'b1;
        tick();
        tests++; if (int'(dut.count) !== 2 || bus.err !== 1'b0) begin
            fails++; $display("FAIL abort_no_pop: got count=%0d err=%b want count=2 err=0", dut.count, bus.err); end
        arm(1'b1, 2);
        for (int k = 0; k < 2; k++) begin
            read_pulse(1'b0, seen, oe_l, oe_h, eop_l);
            tests++; if (seen !== fq[0]) begin fails++; $display("FAIL abort_kept[%0d]: got %h want %h", k, seen, fq[0]); end
            void'(fq.pop_front());
        end
        bus.enable = 1'b0;
        tick();
    endtask

    task automatic test_dreq_threshold();
        int len;
        do_reset();
        len = 6;
        arm(1'b1, len);
        for (int i = 0; i < 6; i++) begin
            push_byte(8'($urandom));
            tests++; if (bus.dreq !== exp_dreq(fq.size(), rem_m)) begin
                fails++; $display("FAIL thr_dreq[%0d]: got %b want %b", i, bus.dreq, exp_dreq(fq.size(), rem_m)); end
        end
        do_reset();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_block();
        test_random_read();
        test_write_block();
        test_eop();
        test_err();
        test_wrap();
        test_abort();
        test_dreq_threshold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
